// File: rtl/fsm_moore_ctrl_if.sv
// Word handshake and serial/status observation bundle for fsm_moore_ctrl.
// The producer uses the master view and the controller uses the slave view.
interface fsm_moore_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             w_out;
   logic             z_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output in_valid, in_data,
      input  in_ready, w_out, z_out, busy, done, match_cnt
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, w_out, z_out, busy, done, match_cnt
   );
endinterface

// File: rtl/fsm_moore_ctrl.sv
// Accepts a word over valid/ready and shifts it MSB-first into a Moore "11" detector.
// Counts detector hits for the word and reports the count with a one-cycle done pulse.
module fsm_moore_ctrl #(
   parameter int WIDTH      = 8,
   parameter int CNT_W      = 4,
   parameter bit CLEAR_EACH = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   fsm_moore_ctrl_if.slave bus
);
   localparam int               BW       = $clog2(WIDTH);
   localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } ctrl_state_e;

   // A: no trailing 1, B: one trailing 1, C: two or more trailing 1s.
   typedef enum logic [1:0] {
      DET_A = 2'd0,
      DET_B = 2'd1,
      DET_C = 2'd2
   } det_state_e;

   ctrl_state_e      state_q, state_d;
   det_state_e       det_q, det_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

   logic w_bit;
   logic z_bit;

   function automatic det_state_e det_next(input det_state_e s, input logic w);
      if (!w) return DET_A;
      return (s == DET_A) ? DET_B : DET_C;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign w_bit = (state_q == SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
   assign z_bit = (det_q == DET_C);

   // NOTE: sequential state uses <= so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         det_q       <= DET_A;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         match_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         det_q       <= det_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   // NOTE: every _d takes its hold value first, so no branch can infer a latch.
   always_comb begin
      state_d     = state_q;
      det_d       = det_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      match_cnt_d = match_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               shreg_d     = bus.in_data;
               bit_cnt_d   = '0;
               match_cnt_d = '0;
               if (CLEAR_EACH) det_d = DET_A;
               state_d     = SHIFT;
            end
         end

         SHIFT: begin
            det_d   = det_next(det_q, w_bit);
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            // z_out lags one bit, so the first SHIFT cycle shows only carried-in state.
            if ((bit_cnt_q != '0) && z_bit) match_cnt_d = sat_inc(match_cnt_q);
            if (bit_cnt_q == LAST_BIT) begin
               state_d = FLUSH;
            end else begin
               bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end

         FLUSH: begin
            if (z_bit) match_cnt_d = sat_inc(match_cnt_q);
            state_d = DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.w_out     = w_bit;
   assign bus.z_out     = z_bit;
   assign bus.match_cnt = match_cnt_q;

   a_done_single: assert property (@(posedge clk) disable iff (!rst)
      bus.done |=> !bus.done);

   a_count_held: assert property (@(posedge clk) disable iff (!rst)
      (state_q == DONE) |=> $stable(match_cnt_q));

endmodule

// File: tb/tb_fsm_moore_ctrl.sv
// Scoreboard bench for fsm_moore_ctrl: one instance clears per word, one carries detector state.
module tb_fsm_moore_ctrl;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   typedef struct {
      int               sel;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fsm_moore_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc0 ();
   fsm_moore_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc1 ();

   fsm_moore_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .CLEAR_EACH(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .bus(ifc0)
   );
   fsm_moore_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .CLEAR_EACH(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .bus(ifc1)
   );

   logic [1:0]       vld;
   logic [WIDTH-1:0] dat [2];
   logic [1:0]       rdy, wo, zo, bsy, dn;
   logic [CNT_W-1:0] mc  [2];

   assign ifc0.in_valid = vld[0];
   assign ifc1.in_valid = vld[1];
   assign ifc0.in_data  = dat[0];
   assign ifc1.in_data  = dat[1];
   assign rdy   = {ifc1.in_ready, ifc0.in_ready};
   assign wo    = {ifc1.w_out, ifc0.w_out};
   assign zo    = {ifc1.z_out, ifc0.z_out};
   assign bsy   = {ifc1.busy, ifc0.busy};
   assign dn    = {ifc1.done, ifc0.done};
   assign mc[0] = ifc0.match_cnt;
   assign mc[1] = ifc1.match_cnt;

   exp_t exp_q[$];
   int   trail [2];
   int   last_acc [2];

   // Sends one word (already at a negedge) and checks every cycle up to the IDLE cycle after done.
   task automatic run_word(input int sel, input logic [WIDTH-1:0] d, input int pulse_c);
      logic       zexp [0:11];
      logic [4:0] exp_v, act_v;
      int         tr, cnt, n;
      exp_t       e;
      logic [CNT_W-1:0] got_cnt;

      vld[sel] = 1'b1;
      dat[sel] = d;
      n = 0;
      while (!rdy[sel] && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (!rdy[sel]) begin
         n_errors++;
         $display("FAIL accept_timeout dut%0d: in_ready=%b required 1", sel, rdy[sel]);
         vld[sel] = 1'b0;
         return;
      end

      tr = (sel == 0) ? 0 : trail[sel];
      cnt = 0;
      zexp[0] = 1'b0;
      zexp[1] = (tr >= 2);
      for (int k = 0; k < WIDTH; k++) begin
         tr = d[WIDTH-1-k] ? ((tr >= 2) ? 2 : tr + 1) : 0;
         zexp[k+2] = (tr >= 2);
         if (tr >= 2 && cnt < (2**CNT_W - 1)) cnt++;
      end
      zexp[10] = zexp[9];
      zexp[11] = zexp[9];
      trail[sel] = tr;
      e.sel = sel;
      e.cnt = CNT_W'(cnt);
      exp_q.push_back(e);

      @(posedge clk);
      @(negedge clk);
      last_acc[sel] = cyc;
      got_cnt = '0;
      for (int c = 1; c <= 11; c++) begin
         if (c == 1) vld[sel] = 1'b0;
         exp_v = {((c <= WIDTH) ? d[WIDTH-c] : 1'b0), zexp[c], (c <= 10), (c == 11), (c == 10)};
         act_v = {wo[sel], zo[sel], bsy[sel], rdy[sel], dn[sel]};
         n_checks++;
         if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL cycle dut%0d word %h c%0d {w,z,busy,ready,done}: got %b required %b",
                     sel, d, c, act_v, exp_v);
         end
         if (c == 10) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL scoreboard_empty dut%0d: done seen with no pending word", sel);
            end else begin
               e = exp_q.pop_front();
               got_cnt = e.cnt;
               if (e.sel != sel || mc[sel] !== e.cnt) begin
                  n_errors++;
                  $display("FAIL match_cnt dut%0d word %h: got %0d required %0d", sel, d, mc[sel], e.cnt);
               end
            end
         end
         if (c == 11) begin
            n_checks++;
            if (mc[sel] !== got_cnt) begin
               n_errors++;
               $display("FAIL match_cnt_held dut%0d: got %0d required %0d", sel, mc[sel], got_cnt);
            end
         end
         if (pulse_c != 0 && c == pulse_c) begin
            vld[sel] = 1'b1;
            dat[sel] = ~d;
         end else if (pulse_c != 0 && c == pulse_c + 1) begin
            vld[sel] = 1'b0;
         end
         if (c < 11) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [5:0] act_v;
      rst = 1'b0;
      vld = 2'b11;
      dat[0] = 8'hFF;
      dat[1] = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            act_v = {rdy[s], bsy[s], dn[s], zo[s], wo[s], |mc[s]};
            n_checks++;
            if (act_v !== 6'b100000) begin
               n_errors++;
               $display("FAIL reset_hold dut%0d {ready,busy,done,z,w,cnt!=0}: got %b required 100000", s, act_v);
            end
         end
      end
      rst = 1'b1;
      vld = 2'b00;
      trail[0] = 0;
      trail[1] = 0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (rdy !== 2'b11 || bsy !== 2'b00) begin
         n_errors++;
         $display("FAIL reset_no_capture: ready=%b busy=%b required 11/00", rdy, bsy);
      end
   endtask

   task automatic test_clear_each();
      run_word(0, 8'hFF, 0);
      run_word(0, 8'hB6, 0);
      run_word(0, 8'h00, 0);
   endtask

   task automatic test_back_to_back();
      int first;
      run_word(1, 8'hFF, 0);
      first = last_acc[1];
      run_word(1, 8'h80, 0);
      n_checks++;
      if (last_acc[1] - first != 11) begin
         n_errors++;
         $display("FAIL back_to_back_spacing: got %0d cycles required 11", last_acc[1] - first);
      end
   endtask

   task automatic test_reset_abort();
      int n;
      bit saw_done;
      vld[0] = 1'b1;
      dat[0] = 8'hFF;
      n = 0;
      while (!rdy[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_in_reset: ready=%b busy=%b done=%b required 1/0/0", rdy[0], bsy[0], dn[0]);
         end
      end
      rst = 1'b1;
      trail[0] = 0;
      trail[1] = 0;
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (dn[0]) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done) begin
         n_errors++;
         $display("FAIL abort_no_done: done=1 seen for discarded word, required none");
      end
      run_word(0, 8'h03, 0);
   endtask

   task automatic test_ignored_valid();
      run_word(0, 8'hB6, 3);
      run_word(1, 8'h6F, 4);
   endtask

   initial begin
      vld = 2'b00;
      dat[0] = '0;
      dat[1] = '0;
      test_reset();
      test_clear_each();
      test_back_to_back();
      test_reset_abort();
      test_ignored_valid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
